// File: rtl/ser_pkg.sv
// Shared definitions for the serial operand driver: FSM state encoding,
// default operand width and a constant-evaluable ceil(log2) helper.
package ser_pkg;

    localparam int SER_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of bits needed to count 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Generic W-bit shift register: synchronous active-low clear, parallel load,
// and enabled shift-right with the serial input entering at the MSB.
// Priority: clear, then load, then shift.
module ser_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         clr_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Clear / load / shift-right register.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (en_i) begin
            q_q <= {ser_i, q_q[W-1:1]};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_operand_driver.sv
// Drive end of a bit-serial adder datapath. Takes an operand pair over a
// valid/ready handshake, shifts both operands out LSB-first, collects the
// returning serial sum bits and offers the parallel result over a second
// valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready. in_ready is high only in IDLE (and
// never while reset is asserted); out_valid is high only in DONE.
//
// Optional build macro SERIAL_DRV_CHECK_EN adds the sum_err output, which
// compares the collected result with a local add of the latched operands.
module serial_operand_driver
    import ser_pkg::*;
#(
    parameter int N   = SER_W,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         ser_start,
    output logic         ser_en,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
`ifdef SERIAL_DRV_CHECK_EN
    output logic         sum_err,
`endif
    output state_t       dbg_state_o
);

    localparam int CW = clog2(N + LAT + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(N + LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q;
    logic          xfer;
    logic          shift_en;
    logic          cap_en;
    logic [N-1:0]  a_q, b_q, res_q;

    assign xfer     = in_valid && in_ready_q;
    assign shift_en = (state_q == S_SHIFT);

    // Sum bit k-LAT arrives in slot k, so capture starts once LAT slots have passed.
    generate
        if (LAT == 0) begin : g_cap_nolat
            assign cap_en = shift_en;
        end else begin : g_cap_lat
            localparam logic [CW-1:0] FIRST_CAP = CW'(LAT);
            assign cap_en = shift_en && (cnt_q >= FIRST_CAP);
        end
    endgenerate

    // Next-state and slot-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_SLOT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and registered in_ready (held low throughout reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == S_IDLE);
        end
    end

    // Operand registers shift in zeros, so slots past bit N-1 drive 0 on their own.
    ser_shift_reg #(.W(N)) u_sr_a (
        .clk_i      (clk),
        .clr_n_i    (rst),
        .load_i     (xfer),
        .load_val_i (op_a),
        .en_i       (shift_en),
        .ser_i      (1'b0),
        .q_o        (a_q)
    );

    ser_shift_reg #(.W(N)) u_sr_b (
        .clk_i      (clk),
        .clr_n_i    (rst),
        .load_i     (xfer),
        .load_val_i (op_b),
        .en_i       (shift_en),
        .ser_i      (1'b0),
        .q_o        (b_q)
    );

    // Result register: cleared on transfer, returning bits enter at the MSB.
    ser_shift_reg #(.W(N)) u_sr_res (
        .clk_i      (clk),
        .clr_n_i    (rst),
        .load_i     (xfer),
        .load_val_i ({N{1'b0}}),
        .en_i       (cap_en),
        .ser_i      (ser_s),
        .q_o        (res_q)
    );

    assign in_ready    = in_ready_q;
    assign ser_start   = (state_q == S_START);
    assign ser_en      = shift_en;
    assign ser_a       = shift_en && a_q[0];
    assign ser_b       = shift_en && b_q[0];
    assign out_valid   = (state_q == S_DONE);
    assign out_sum     = res_q;
    assign dbg_state_o = state_q;

`ifdef SERIAL_DRV_CHECK_EN
    logic [N-1:0] opa_keep_q, opb_keep_q;
    logic [N-1:0] ref_sum;

    // Untouched copies of the operands, kept for the result cross-check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            opa_keep_q <= '0;
            opb_keep_q <= '0;
        end else if (xfer) begin
            opa_keep_q <= op_a;
            opb_keep_q <= op_b;
        end
    end

    assign ref_sum = opa_keep_q + opb_keep_q;
    assign sum_err = (state_q == S_DONE) && (res_q != ref_sum);
`endif

endmodule
